// File: rtl/rv_uart_tx.sv
// Byte-serial 8N1 UART transmitter fed by a small byte FIFO.
// Latency: start bit on tx_o one clock after a byte is written into an idle, empty block.
// Backpressure: wr_ready_o drops while the FIFO holds DEPTH bytes; frames follow back-to-back.

module rv_uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     push_vld,
    output logic                     push_rdy,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;

    // Readiness depends only on the registered count, so a same-cycle pop never frees a slot.
    assign push_rdy = (count != (AW + 1)'(DEPTH));
    assign pop_vld  = (count != '0);
    assign push     = push_vld & push_rdy;
    assign pop      = pop_rdy & pop_vld;
    assign pop_dat  = mem[rptr];

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_dat;
    end
endmodule

module rv_uart_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     wr_valid_i,
    input  logic [7:0]               wr_data_i,
    output logic                     wr_ready_o,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_d;
    logic          tx_q, tx_d;
    logic          pop;
    logic          fifo_vld;
    logic [7:0]    fifo_dat;
    logic [7:0]    shreg;
    logic          bit_end;

    rv_uart_tx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk      (clk),
        .arstn    (arstn),
        .push_vld (wr_valid_i),
        .push_rdy (wr_ready_o),
        .push_dat (wr_data_i),
        .pop_rdy  (pop),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_dat),
        .count    (fifo_count_o)
    );

    assign bit_end = (cnt == CNT_LAST);

    always_comb begin
        state_d = state;
        cnt_d   = bit_end ? '0 : cnt + 1'b1;
        bit_d   = bit_idx;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (fifo_vld) begin
                    pop     = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                        tx_d  = shreg[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes are waiting.
                if (bit_end) begin
                    if (fifo_vld) begin
                        pop     = 1'b1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            tx_q    <= tx_d;
        end
    end

    // Holds the frame byte so later writes cannot disturb the bits on the line.
    always_ff @(posedge clk) begin
        if (pop) shreg <= fifo_dat;
    end

    assign tx_o   = tx_q;
    assign busy_o = (state != IDLE) || (fifo_count_o != '0);
endmodule

// File: tb/tb_rv_uart_tx.sv
// Directed bench for rv_uart_tx: DIV=8 instance for framing/FIFO/reset cases,
// plus a default-parameter instance for the 434-clock bit period.
module tb_rv_uart_tx;
    logic       clk;
    logic       arstn;
    logic       wr_valid_i;
    logic [7:0] wr_data_i;
    logic       wr_ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] fifo_count_o;

    logic       d_wr_valid;
    logic [7:0] d_wr_data;
    logic       d_wr_ready;
    logic       d_tx;
    logic       d_busy;
    logic [2:0] d_count;

    int checks = 0;
    int errors = 0;

    rv_uart_tx #(.CLK_HZ(8), .BAUD(1), .DEPTH(4)) dut (
        .clk          (clk),
        .arstn        (arstn),
        .wr_valid_i   (wr_valid_i),
        .wr_data_i    (wr_data_i),
        .wr_ready_o   (wr_ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    rv_uart_tx dut_def (
        .clk          (clk),
        .arstn        (arstn),
        .wr_valid_i   (d_wr_valid),
        .wr_data_i    (d_wr_data),
        .wr_ready_o   (d_wr_ready),
        .tx_o         (d_tx),
        .busy_o       (d_busy),
        .fifo_count_o (d_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level at bit position p (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int p);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    task automatic test_reset();
        arstn = 1'b0;
        wr_valid_i = 1'b0;
        wr_data_i = 8'h00;
        d_wr_valid = 1'b0;
        d_wr_data = 8'h00;
        #2;
        tick();
        tick();
        checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", wr_ready_o); end
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count_o); end
        checks++; if (d_tx !== 1'b1) begin errors++; $display("FAIL reset_def_tx got=%b exp=1", d_tx); end
        arstn = 1'b1;
        tick();
        tick();
        checks++; if (tx_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle tx=%b busy=%b exp tx=1 busy=0", tx_o, busy_o); end
    endtask

    task automatic test_single();
        logic [7:0] b;
        b = 8'h41;
        wr_data_i = b;
        wr_valid_i = 1'b1;
        checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", wr_ready_o); end
        tick();
        wr_valid_i = 1'b0;
        checks++; if (fifo_count_o !== 3'd1) begin errors++; $display("FAIL single_count_push got=%0d exp=1", fifo_count_o); end
        checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL single_prestart got=%b exp=1", tx_o); end
        tick();
        for (int k = 0; k < 80; k++) begin
            wr_data_i = 8'($urandom);
            checks++;
            if (tx_o !== frame_bit(b, k / 8)) begin
                errors++; $display("FAIL single_bit k=%0d got=%b exp=%b", k, tx_o, frame_bit(b, k / 8));
            end
            if (k == 0) begin
                checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL single_count_pop got=%0d exp=0", fifo_count_o); end
            end
            if (k == 79) begin
                checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_stop got=%b exp=1", busy_o); end
            end
            tick();
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy_o); end
        checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL single_idle_tx got=%b exp=1", tx_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bb [4];
        int ec;
        bb = '{8'h00, 8'hFF, 8'h55, 8'hA5};
        for (int i = 0; i < 4; i++) begin
            wr_data_i = bb[i];
            wr_valid_i = 1'b1;
            checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_push_ready i=%0d got=%b exp=1", i, wr_ready_o); end
            tick();
        end
        wr_valid_i = 1'b0;
        for (int k = 2; k < 320; k++) begin
            ec = (k < 80) ? 3 : 3 - k / 80;
            checks++;
            if (tx_o !== frame_bit(bb[k / 80], (k % 80) / 8)) begin
                errors++; $display("FAIL b2b_bit k=%0d got=%b exp=%b", k, tx_o, frame_bit(bb[k / 80], (k % 80) / 8));
            end
            checks++;
            if (fifo_count_o !== 3'(ec)) begin
                errors++; $display("FAIL b2b_count k=%0d got=%0d exp=%0d", k, fifo_count_o, ec);
            end
            checks++;
            if (wr_ready_o !== 1'b1) begin
                errors++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, wr_ready_o);
            end
            tick();
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", busy_o); end
    endtask

    // Six writes with valid held: fills the FIFO, stalls, and hits the full-plus-pop edge.
    task automatic test_fill();
        logic [7:0] fb [6];
        int ec;
        fb = '{8'h11, 8'h22, 8'h3C, 8'h81, 8'hE7, 8'h96};
        for (int i = 0; i < 5; i++) begin
            wr_data_i = fb[i];
            wr_valid_i = 1'b1;
            checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL fill_push_ready i=%0d got=%b exp=1", i, wr_ready_o); end
            tick();
        end
        wr_data_i = fb[5];
        for (int k = 3; k < 480; k++) begin
            if (k < 80) ec = 4;
            else if (k == 80) ec = 3;
            else ec = 5 - k / 80;
            checks++;
            if (fifo_count_o !== 3'(ec)) begin
                errors++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, fifo_count_o, ec);
            end
            checks++;
            if (wr_ready_o !== (ec != 4)) begin
                errors++; $display("FAIL fill_ready k=%0d got=%b exp=%b", k, wr_ready_o, (ec != 4));
            end
            checks++;
            if (tx_o !== frame_bit(fb[k / 80], (k % 80) / 8)) begin
                errors++; $display("FAIL fill_bit k=%0d got=%b exp=%b", k, tx_o, frame_bit(fb[k / 80], (k % 80) / 8));
            end
            if (k == 81) wr_valid_i = 1'b0;
            tick();
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fill_busy_end got=%b exp=0", busy_o); end
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL fill_count_end got=%0d exp=0", fifo_count_o); end
    endtask

    task automatic test_reset_mid();
        wr_valid_i = 1'b1;
        wr_data_i = 8'h00;
        tick();
        wr_data_i = 8'hAA;
        tick();
        wr_data_i = 8'h0F;
        tick();
        wr_valid_i = 1'b0;
        checks++; if (fifo_count_o !== 3'd2) begin errors++; $display("FAIL rstmid_queued got=%0d exp=2", fifo_count_o); end
        repeat (29) tick();
        checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx got=%b exp=0", tx_o); end
        #2;
        arstn = 1'b0;
        #1;
        checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL rstmid_tx got=%b exp=1", tx_o); end
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
        checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", wr_ready_o); end
        #1;
        arstn = 1'b1;
        tick();
        for (int k = 0; k < 200; k++) begin
            checks++;
            if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
                errors++; $display("FAIL rstmid_after k=%0d tx=%b busy=%b exp tx=1 busy=0", k, tx_o, busy_o);
            end
            tick();
        end
    endtask

    task automatic test_defaults();
        logic [7:0] b;
        b = 8'hC3;
        d_wr_data = b;
        d_wr_valid = 1'b1;
        tick();
        d_wr_valid = 1'b0;
        d_wr_data = 8'h3C;
        tick();
        for (int k = 0; k < 4340; k++) begin
            checks++;
            if (d_tx !== frame_bit(b, k / 434)) begin
                errors++; $display("FAIL def_bit k=%0d got=%b exp=%b", k, d_tx, frame_bit(b, k / 434));
            end
            tick();
        end
        checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL def_busy_end got=%b exp=0", d_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_reset_mid();
        test_defaults();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_uart_tx.md
RV_UART_TX -- requirements
Module: rv_uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 arstn  input  1  reset, asynchronous, active-low.
REQ-006 wr_valid_i  input  1  byte-write request from bus-side UART driver.
REQ-007 wr_data_i  input  8  byte to transmit; sampled when wr_valid_i & wr_ready_o.
REQ-008 wr_ready_o  output  1  FIFO can accept a byte this cycle.
REQ-009 tx_o  output  1  serial line, 8N1, idle high, registered.
REQ-010 busy_o  output  1  FIFO non-empty or frame in progress.
REQ-011 fifo_count_o  output  $clog2(DEPTH)+1  bytes currently queued, not counting the byte being shifted.

Function
REQ-012 Bit period DIV SHALL be CLK_HZ/BAUD, integer truncation (434 at defaults); each bit SHALL hold for exactly DIV clocks.
REQ-013 Baud counter SHALL count 0..DIV-1, restart at 0 on every bit boundary and on frame start; no fractional accumulation.
REQ-014 FIFO: circular buffer, DEPTH entries, read/write pointers wrap modulo DEPTH; count SHALL track occupancy 0..DEPTH.
REQ-015 wr_ready_o SHALL equal (count != DEPTH); push occurs iff wr_valid_i & wr_ready_o.
REQ-016 When full, push SHALL be refused even if a pop occurs in the same cycle.
REQ-017 Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-018 FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: tx_o=1; if count != 0 at an edge, pop head byte into shift register, go to START; tx_o=0 from that edge.
REQ-020 Push into empty FIFO at edge N SHALL produce start-bit falling edge on tx_o at edge N+1; a byte is never popped the same cycle it is pushed.
REQ-021 START: tx_o=0 for DIV clocks, then DATA.
REQ-022 DATA: 8 bits LSB first, each DIV clocks; 3-bit bit index; after bit 7 go to STOP.
REQ-023 STOP: tx_o=1 for DIV clocks; at end, if count != 0, pop and go directly to START (back-to-back frames, no idle gap); else IDLE.
REQ-024 Frame length SHALL be exactly 10*DIV clocks.
REQ-025 busy_o SHALL be 1 in START/DATA/STOP or when count != 0; 0 otherwise.
REQ-026 wr_data_i changes while a frame is in progress SHALL not affect the current frame.

Reset
REQ-027 arstn low SHALL immediately force: tx_o=1, state IDLE, pointers 0, count 0, baud counter 0, bit index 0, busy_o=0, wr_ready_o=1.
REQ-028 Reset mid-frame SHALL abort the frame (line returns high asynchronously) and discard all queued bytes.
REQ-029 Shift register and FIFO storage need no reset; their contents SHALL never reach tx_o without a prior push.

Verification (bench uses CLK_HZ=8, BAUD=1, DIV=8 unless stated)
REQ-030 Single byte 0x41 pushed into empty idle block -> tx_o low at next edge; sequence 0,1,0,0,0,0,0,1,0,1 each 8 clocks (80 total); busy_o drops after stop bit.
REQ-031 Push 0x00,0xFF,0x55,0xA5 back-to-back -> wr_ready_o never low (DEPTH=4, one popped immediately); four contiguous 80-clock frames, no idle gap, fifo_count_o 3->2->1->0.
REQ-032 Push 6 bytes with wr_valid_i held -> after pop of first, FIFO fills, wr_ready_o=0 at count 4; push attempted at full stalls; all 6 bytes transmitted in order.
REQ-033 Full FIFO with pop at STOP end and wr_valid_i=1 same cycle -> push refused, count 4->3, accepted next cycle.
REQ-034 arstn asserted at clock 30 of a frame with 2 bytes queued -> tx_o=1 immediately, count 0, busy_o=0; no further frames after release.
REQ-035 Defaults (50 MHz, 115200) byte 0xC3 -> bit period 434 clocks, frame 4340 clocks, data LSB first.
